// File: rtl/seg7_bcd_counter_mux.sv
// rtl/seg7_bcd_counter_mux.sv - prescaled up/down BCD counter with multiplexed seven-segment drive
module seg7_bcd_counter_mux #(
    parameter int CLK_HZ      = 10_000_000,
    parameter int TICK_HZ     = 1,
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 1024,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic                  run,
    input  logic                  dir,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tick,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [6:0]    SEG_MASK   = SEG_ACT_LOW ? 7'h7F : 7'h00;

    // Active-high glyph {g,f,e,d,c,b,a}; unreachable codes 10-15 decode blank.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b0111111;
            4'd1:    glyph = 7'b0000110;
            4'd2:    glyph = 7'b1011011;
            4'd3:    glyph = 7'b1001111;
            4'd4:    glyph = 7'b1100110;
            4'd5:    glyph = 7'b1101101;
            4'd6:    glyph = 7'b1111101;
            4'd7:    glyph = 7'b0000111;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1101111;
            default: glyph = 7'b0000000;
        endcase
    endfunction

    logic [PW-1:0]         presc_q, presc_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  wrap_q, wrap_d;
    logic                  tick_c;
    logic [SW-1:0]         scan_q, scan_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DIGITS-1:0]     sel_q, sel_d;
    logic [6:0]            seg_q, seg_d;
    logic                  carry;
    logic [3:0]            dig;
    logic [3:0]            shown;

    // Prescaler and counter next state: clear beats load beats the tick step; ena low freezes all.
    always_comb begin
        presc_d = presc_q;
        bcd_d   = bcd_q;
        wrap_d  = 1'b0;
        tick_c  = 1'b0;
        carry   = 1'b0;
        dig     = 4'd0;
        if (ena) begin
            if (clear) begin
                presc_d = '0;
                bcd_d   = '0;
            end else if (load) begin
                presc_d = '0;
                for (int i = 0; i < DIGITS; i++) begin
                    dig = load_val[4*i +: 4];
                    bcd_d[4*i +: 4] = (dig > 4'd9) ? 4'd9 : dig;
                end
            end else if (run) begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_c  = 1'b1;
                    carry   = 1'b1;
                    for (int i = 0; i < DIGITS; i++) begin
                        dig = bcd_q[4*i +: 4];
                        if (carry) begin
                            if (!dir) begin
                                if (dig >= 4'd9) begin
                                    bcd_d[4*i +: 4] = 4'd0;
                                end else begin
                                    bcd_d[4*i +: 4] = dig + 4'd1;
                                    carry = 1'b0;
                                end
                            end else begin
                                if (dig == 4'd0) begin
                                    bcd_d[4*i +: 4] = 4'd9;
                                end else begin
                                    bcd_d[4*i +: 4] = dig - 4'd1;
                                    carry = 1'b0;
                                end
                            end
                        end
                    end
                    // Carry surviving past the top digit means every digit rolled over.
                    wrap_d = carry;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
        end
    end

    // Scan timebase, digit index and the registered one-hot select / segment pattern.
    always_comb begin
        scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        sel_d = '0;
        shown = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                sel_d[i] = 1'b1;
                shown    = bcd_q[4*i +: 4];
            end
        end
        seg_d = glyph(shown) ^ SEG_MASK;
    end

    // State registers; reset returns every register to its idle value immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            bcd_q   <= '0;
            wrap_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            sel_q   <= DIGITS'(1);
            seg_q   <= glyph(4'd0) ^ SEG_MASK;
        end else begin
            presc_q <= presc_d;
            bcd_q   <= bcd_d;
            wrap_q  <= wrap_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
        end
    end

    assign bcd       = bcd_q;
    assign tick      = tick_c;
    assign wrap      = wrap_q;
    assign seg       = seg_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_seg7_bcd_counter_mux.sv
// tb/tb_seg7_bcd_counter_mux.sv - scoreboard bench for seg7_bcd_counter_mux
module tb_seg7_bcd_counter_mux;

    localparam logic [6:0] SEG_L_0 = 7'b1000000;
    localparam logic [6:0] SEG_L_5 = 7'b0010010;
    localparam logic [6:0] SEG_L_7 = 7'b1111000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b0;
    logic       run = 1'b0;
    logic       dir = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] bcd;
    logic       tick;
    logic       wrap;
    logic [6:0] seg;
    logic [1:0] digit_sel;

    seg7_bcd_counter_mux #(
        .CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .SCAN_DIV(4), .SEG_ACT_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .ena(ena), .run(run), .dir(dir),
        .clear(clear), .load(load), .load_val(load_val),
        .bcd(bcd), .tick(tick), .wrap(wrap), .seg(seg), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    bit scan_chk = 1'b0;

    typedef struct { logic [7:0] bcd; logic wrap; } cnt_exp_t;
    typedef struct { logic [1:0] sel; logic [6:0] seg; } scan_exp_t;
    cnt_exp_t  cnt_q[$];
    scan_exp_t scan_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_cnt(input logic [7:0] b, input logic w);
        cnt_exp_t e;
        e.bcd = b;
        e.wrap = w;
        cnt_q.push_back(e);
    endtask

    task automatic push_scan(input logic [1:0] s, input logic [6:0] g);
        scan_exp_t e;
        e.sel = s;
        e.seg = g;
        scan_q.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (cnt_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, cnt_q.size(), 0);
    endtask

    task automatic pulse(input logic c, input logic l, input logic [7:0] v);
        clear = c;
        load = l;
        load_val = v;
        @(posedge clk);
        #1;
        clear = 1'b0;
        load = 1'b0;
    endtask

    task automatic wait_sel(input logic [1:0] s);
        int n = 0;
        while (digit_sel !== s && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_digit_sel", digit_sel, s);
    endtask

    // Monitor: every count change (or wrap pulse) consumes one expected count entry;
    // every select change while armed consumes one expected scan entry.
    initial begin
        logic [7:0] prev_bcd = 8'h00;
        logic [1:0] prev_sel = 2'b01;
        int last_sel_cyc = 0;
        cnt_exp_t ce;
        scan_exp_t se;
        forever begin
            @(negedge clk);
            if (bcd !== prev_bcd || wrap === 1'b1) begin
                if (cnt_q.size() == 0) begin
                    check("unexpected_count_event", {23'd0, bcd, wrap}, {23'd0, prev_bcd, 1'b0});
                end else begin
                    ce = cnt_q.pop_front();
                    check("count_bcd", bcd, ce.bcd);
                    check("count_wrap", wrap, ce.wrap);
                end
            end
            prev_bcd = bcd;
            if (digit_sel !== prev_sel) begin
                if (scan_chk) begin
                    check("scan_interval", cyc - last_sel_cyc, 4);
                    if (scan_q.size() == 0) begin
                        check("unexpected_scan_event", 1, 0);
                    end else begin
                        se = scan_q.pop_front();
                        check("scan_sel", digit_sel, se.sel);
                        check("scan_seg", seg, se.seg);
                    end
                end
                last_sel_cyc = cyc;
                prev_sel = digit_sel;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 10000", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        int sel_changes;
        logic [1:0] last_sel;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_bcd", bcd, 8'h00);
        check("reset_tick", tick, 1'b0);
        check("reset_wrap", wrap, 1'b0);
        check("reset_digit_sel", digit_sel, 2'b01);
        check("reset_seg", seg, SEG_L_0);

        // 1: count up 00..10, one tick every 10 clocks
        for (int i = 1; i <= 9; i++) push_cnt(8'(i), 1'b0);
        push_cnt(8'h10, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ena = 1'b1;
        run = 1'b1;
        dir = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tick === 1'b1) n++;
        end
        check("ticks_in_100_clks", n, 10);
        drain("drain_count_up", 20);

        // 2: load 98, roll 99 -> 00 with wrap
        push_cnt(8'h98, 1'b0);
        push_cnt(8'h99, 1'b0);
        push_cnt(8'h00, 1'b1);
        pulse(1'b0, 1'b1, 8'h98);
        drain("drain_wrap_up", 40);

        // 3: count down 00 -> 99 with wrap, then 10 -> 09
        push_cnt(8'h99, 1'b1);
        dir = 1'b1;
        drain("drain_wrap_down", 20);
        push_cnt(8'h10, 1'b0);
        push_cnt(8'h09, 1'b0);
        pulse(1'b0, 1'b1, 8'h10);
        drain("drain_borrow", 30);

        // 4: clear wins over load and zeroes the prescaler
        dir = 1'b0;
        push_cnt(8'h00, 1'b0);
        push_cnt(8'h01, 1'b0);
        pulse(1'b1, 1'b1, 8'h42);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (tick === 1'b1) break;
        end
        check("clear_to_tick_latency", n, 10);
        drain("drain_clear", 5);
        run = 1'b0;
        push_cnt(8'h97, 1'b0);
        pulse(1'b0, 1'b1, 8'hA7);
        push_cnt(8'h99, 1'b0);
        pulse(1'b0, 1'b1, 8'hFC);
        drain("drain_clamp", 5);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tick === 1'b1) n++;
        end
        check("paused_ticks", n, 0);

        // 5: scan alternates digits every 4 clocks with matching glyphs
        push_cnt(8'h57, 1'b0);
        pulse(1'b0, 1'b1, 8'h57);
        drain("drain_load57", 5);
        wait_sel(2'b10);
        push_scan(2'b01, SEG_L_7);
        push_scan(2'b10, SEG_L_5);
        push_scan(2'b01, SEG_L_7);
        push_scan(2'b10, SEG_L_5);
        scan_chk = 1'b1;
        n = 0;
        while (scan_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_scan", scan_q.size(), 0);
        scan_chk = 1'b0;

        // 6: async reset mid-scan, then ena low freezes count but not scan
        push_cnt(8'h55, 1'b0);
        pulse(1'b0, 1'b1, 8'h55);
        drain("drain_load55", 5);
        wait_sel(2'b10);
        @(posedge clk);
        #2;
        push_cnt(8'h00, 1'b0);
        reset = 1'b1;
        #1;
        check("async_reset_bcd", bcd, 8'h00);
        check("async_reset_tick", tick, 1'b0);
        check("async_reset_wrap", wrap, 1'b0);
        check("async_reset_digit_sel", digit_sel, 2'b01);
        check("async_reset_seg", seg, SEG_L_0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        ena = 1'b0;
        run = 1'b1;
        pulse(1'b0, 1'b1, 8'h33);
        pulse(1'b1, 1'b0, 8'h00);
        n = 0;
        sel_changes = 0;
        last_sel = digit_sel;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tick === 1'b1) n++;
            if (digit_sel !== last_sel) sel_changes++;
            last_sel = digit_sel;
        end
        check("disabled_ticks", n, 0);
        check("disabled_bcd", bcd, 8'h00);
        check("disabled_scan_moves", (sel_changes >= 7) ? 1 : 0, 1);
        check("final_count_queue_empty", cnt_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
